// File: rtl/audio_synth.sv
// Two-channel square-wave tone synthesizer with a linear attack envelope,
// shared volume/mute, and registered signed 16-bit outputs.

module audio_synth_chan #(
  parameter int DIV_W    = 22,
  parameter int RAMP_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] note_div_i,
  input  logic [15:0]      base_amp_i,
  input  logic             mute_i,
  output logic [15:0]      sample_o
);

  localparam logic [15:0] RAMP_LAST = 16'(RAMP_CYC - 1);
  localparam logic [3:0]  ENV_MAX   = 4'd8;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] prev_div_q, prev_div_d;
  logic [3:0]       env_step_q, env_step_d;
  logic [15:0]      ramp_cnt_q, ramp_cnt_d;
  logic [15:0]      sample_q, sample_d;

  logic        silent;
  logic        note_change;
  logic [19:0] amp_full;
  logic [14:0] amp;

  assign silent      = (note_div_i < DIV_W'(2));
  assign note_change = (note_div_i != prev_div_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    env_step_d = env_step_q;
    ramp_cnt_d = ramp_cnt_q;
    prev_div_d = note_div_i;

    if (note_change || silent) begin
      cnt_d      = '0;
      phase_d    = 1'b0;
      env_step_d = '0;
      ramp_cnt_d = '0;
    end else begin
      if (cnt_q == note_div_i - DIV_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      // Ramp counter keeps wrapping after saturation; only the step holds.
      if (ramp_cnt_q == RAMP_LAST) begin
        ramp_cnt_d = '0;
        if (env_step_q < ENV_MAX) begin
          env_step_d = env_step_q + 4'd1;
        end
      end else begin
        ramp_cnt_d = ramp_cnt_q + 16'd1;
      end
    end
  end

  // base <= 0x4000 and env_step <= 8, so the shifted product always fits 15 bits.
  assign amp_full = (20'(base_amp_i) * 20'(env_step_q)) >> 3;
  assign amp      = amp_full[14:0];

  always_comb begin
    sample_d = '0;
    if (!mute_i && !silent && (amp != '0)) begin
      sample_d = phase_q ? {1'b0, amp} : (16'd0 - {1'b0, amp});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      prev_div_q <= '0;
      env_step_q <= '0;
      ramp_cnt_q <= '0;
      sample_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      prev_div_q <= prev_div_d;
      env_step_q <= env_step_d;
      ramp_cnt_q <= ramp_cnt_d;
      sample_q   <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

module audio_synth #(
  parameter int DIV_W    = 22,
  parameter int RAMP_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] note_div_left,
  input  logic [DIV_W-1:0] note_div_right,
  input  logic [2:0]       volume,
  input  logic             mute,
  output logic [15:0]      audio_left,
  output logic [15:0]      audio_right
);

  logic [15:0] base_amp;

  // Volume 6 and 7 clamp to the loudest level.
  always_comb begin
    case (volume)
      3'd0:    base_amp = 16'h0000;
      3'd1:    base_amp = 16'h0400;
      3'd2:    base_amp = 16'h0800;
      3'd3:    base_amp = 16'h1000;
      3'd4:    base_amp = 16'h2000;
      default: base_amp = 16'h4000;
    endcase
  end

  audio_synth_chan #(
    .DIV_W    (DIV_W),
    .RAMP_CYC (RAMP_CYC)
  ) u_left (
    .clk        (clk),
    .reset_n    (reset_n),
    .note_div_i (note_div_left),
    .base_amp_i (base_amp),
    .mute_i     (mute),
    .sample_o   (audio_left)
  );

  audio_synth_chan #(
    .DIV_W    (DIV_W),
    .RAMP_CYC (RAMP_CYC)
  ) u_right (
    .clk        (clk),
    .reset_n    (reset_n),
    .note_div_i (note_div_right),
    .base_amp_i (base_amp),
    .mute_i     (mute),
    .sample_o   (audio_right)
  );

endmodule

// File: doc/audio_synth.md
AUDIO_SYNTH -- requirements
Module: audio_synth

Interface
REQ-001 The block SHALL have parameter DIV_W, default 22, giving the note-divider width in bits.
REQ-002 The block SHALL have parameter RAMP_CYC, default 1024, giving the clock cycles per envelope step (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port note_div_left, input, DIV_W, the left-channel half-period in clk cycles, where values 0 and 1 mean silence.
REQ-006 The block SHALL have port note_div_right, input, DIV_W, the right-channel half-period in clk cycles, with the same silence rule.
REQ-007 The block SHALL have port volume, input, 3, the volume level, where 0 means silent and 6 or 7 are treated as 5.
REQ-008 The block SHALL have port mute, input, 1, which forces both outputs to 0 while high.
REQ-009 The block SHALL have port audio_left, output, 16, the signed two's-complement left sample, registered.
REQ-010 The block SHALL have port audio_right, output, 16, the signed two's-complement right sample, registered.

Function (each channel independent and identical; div = that channel's note_div)
REQ-011 Each channel SHALL hold the following state:
- cnt (DIV_W bits)
- phase (1 bit)
- prev_div (DIV_W bits)
- env_step (0..8)
- ramp_cnt (16 bits)
REQ-012 The active tone SHALL behave as follows when div >= 2 and div == prev_div:
- cnt increments by 1 each cycle.
- When cnt == div-1, cnt <= 0 and phase toggles.
- Tone period is therefore 2*div cycles.
REQ-013 A note change SHALL behave as follows when div != prev_div:
- At that clock edge, cnt <= 0, phase <= 0, env_step <= 0, ramp_cnt <= 0, and prev_div <= div.
- Any cycle with div != prev_div is a note change, including consecutive ones.
REQ-014 Silence SHALL behave as follows when div < 2:
- cnt, phase, env_step and ramp_cnt are held at 0.
- prev_div still tracks div.
REQ-015 The envelope SHALL behave as follows while the tone is active:
- ramp_cnt increments each cycle.
- When ramp_cnt == RAMP_CYC-1, ramp_cnt <= 0 and env_step increments, saturating at 8.
- At saturation, ramp_cnt keeps wrapping and env_step stays 8.
REQ-016 The base amplitude SHALL be 16'h0000, 16'h0400, 16'h0800, 16'h1000, 16'h2000 or 16'h4000 for volume 0, 1, 2, 3, 4 and 5 respectively (6 and 7 map to 16'h4000).
REQ-017 The amplitude SHALL be amp = (base * env_step) >> 3, computed at 20-bit intermediate width and truncated to 15 bits without overflow.
REQ-018 The output register SHALL load, each cycle:
- 0 when mute = 1, the channel is silent, or amp = 0;
- otherwise +amp when phase = 1 and -amp (two's complement) when phase = 0.
REQ-019 Latency from the phase/env_step state to the output register SHALL be exactly 1 clk cycle.
REQ-020 A change to volume SHALL take effect on the next output without restarting the envelope.
REQ-021 mute SHALL affect only the output and SHALL NOT stop or reset cnt, phase or the envelope.
REQ-022 The left and right channels SHALL share volume and mute only; they SHALL have no other cross-coupling.

Reset
REQ-023 While reset_n = 0, asynchronously, both channels' cnt, phase, env_step and ramp_cnt SHALL be 0.
REQ-024 While reset_n = 0, prev_div SHALL be 0.
REQ-025 While reset_n = 0, audio_left and audio_right SHALL be 16'h0000.
REQ-026 Because prev_div = 0 after reset, the first div >= 2 after reset_n rises SHALL be treated as a note change.
REQ-027 A reset asserted mid-note SHALL immediately zero the outputs, and the note SHALL restart from phase 0 and env_step 0 after release.

Verification
REQ-028 Reset scenario: assert reset_n = 0 with div = 100 and volume = 5 -> both outputs = 0 immediately; after release, 0 until env_step reaches 1.
REQ-029 Steady-tone scenario: RAMP_CYC = 4, div_left = 4, volume = 3, run 40 cycles -> audio_left alternates 16'h1000 and 16'hF000 every 4 cycles at full envelope (period 8); audio_right = 0 with div_right = 0.
REQ-030 Ramp scenario: RAMP_CYC = 4, volume = 5, fresh note -> magnitude steps through 0, 0x0800, 0x1000 … 0x4000, one step every 4 cycles, then holds.
REQ-031 Note-change scenario: change div_left from 4 to 6 mid-period -> next edge cnt = 0, phase = 0, env restarts; new half-period is 6 cycles; right channel is unaffected.
REQ-032 Volume/mute scenario: volume = 7 -> full-envelope magnitude 16'h4000; mute pulse of 3 cycles -> outputs 0 for those cycles, then resume with unchanged phase and envelope.
REQ-033 Silence scenario: div = 1 -> output 0 and state held at 0; then div = 2 -> tone with period 4 starting at phase 0.
